key_cmd_encoder: RTL and testbench
==================================

Name: key_cmd_encoder

Overview:
- Front-end for the VGA gomoku board. Turns five raw push-buttons into the one-hot 5-bit move/place command (`yidong`) and the player-turn `flag` that the board/display block consumes.
- Synchronises and debounces each button.
- Emits one clean command per press, with auto-repeat on direction keys.
- Stretches each command so the board's slow command clock (period 2*(7000000+1) clk cycles) samples it at least once, but never twice.

Parameters:
- DEBOUNCE_CYC, 2000000, cycles a synchronised button must be stable before its debounced level changes (20 ms at 100 MHz).
- HOLD_CYC, 14000002, cycles a command is driven on `yidong`; must be ≥ 1 and ≤ 1 slow-clock period.
- REPEAT_DLY, 50000000, cycles a direction key must stay held after its first command before auto-repeat starts.
- REPEAT_GAP, 14000002, idle cycles between auto-repeated commands (measured from end of HOLD).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous reset, active-high.
- btn_up  in  1  raw button, asynchronous, 1 = pressed.
- btn_down  in  1  raw button, asynchronous, 1 = pressed.
- btn_left  in  1  raw button, asynchronous, 1 = pressed.
- btn_right  in  1  raw button, asynchronous, 1 = pressed.
- btn_place  in  1  raw button, asynchronous, 1 = pressed.
- yidong  out  5  one-hot command: 00001 up, 00010 down, 00100 left, 01000 right, 10000 place; 00000 = none.
- flag  out  1  current player, 0/1; toggles after each place command.
- busy  out  1  high while a command is being driven (HOLD state).

Behaviour:
- Clock/reset: single clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values:
  - yidong = 0, flag = 0, busy = 0.
  - All synchronisers, debounced levels and counters = 0.
  - FSM = IDLE.
  - `rst` mid-HOLD aborts the command next edge; flag is not toggled.
- Synchronisation: each button passes a 2-flop synchroniser, giving 2 cycles of latency.
- Debounce, per button:
  - A counter runs while the synchronised level differs from the debounced level, and clears to 0 when they are equal.
  - When the counter reaches DEBOUNCE_CYC-1, the debounced level flips and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYC+1).
- Valid key vector: `key[4:0] = {place, right, left, down, up}` debounced. Valid only when exactly one bit is set (onehot); 0 or ≥ 2 bits set counts as no key.
- FSM:
  - IDLE:
    - yidong = 0.
    - If key is onehot: latch `cmd = key`, load the hold counter, go to HOLD.
  - HOLD:
    - yidong = cmd, busy = 1, for exactly HOLD_CYC cycles.
    - Then go to WAIT. If cmd == 10000, toggle flag on the same edge.
  - WAIT:
    - yidong = 0.
    - If `key & cmd == 0` (key released): go to IDLE.
    - Else, if cmd is a direction key and the repeat timer has expired: go to HOLD with the same cmd.
    - Repeat timer:
      - Loaded with REPEAT_DLY on the first entry to WAIT after a press from IDLE.
      - Loaded with REPEAT_GAP on entry to WAIT after a repeat.
      - Counts down to 0.
    - Place key never repeats; it waits for release.
    - A second key pressed while in HOLD/WAIT is ignored until the held key is released and the FSM is back in IDLE. After that, a still-held other key is accepted if it is onehot.
- Latency: raw press to yidong != 0 is 2 + DEBOUNCE_CYC + 1 cycles (± 1).
- flag stability:
  - flag is stable during HOLD, so the consumer samples yidong and flag consistently.
  - The flag toggle is registered and appears the cycle after HOLD ends.
- Counter widths: sized by $clog2 of the max of the relevant parameters. No wrap; counters saturate/stop at 0.

Test Plan:
Sim parameters: DEBOUNCE_CYC=4, HOLD_CYC=8, REPEAT_DLY=20, REPEAT_GAP=10.
1. Reset, then hold btn_left high 3 cycles with bounce (1,0,1,0), then steady high for 40 cycles → yidong = 00100 for exactly 8 cycles, first assertion ~7 cycles after the steady edge. Repeat pulses 00100 start 20 idle cycles after the first HOLD ends and recur every 10 idle cycles; flag stays 0.
2. Press btn_place for 30 cycles then release; press again → yidong = 10000 for 8 cycles each press, no repeat while held. flag goes 0→1 after the first HOLD and 1→0 after the second.
3. btn_up and btn_right pressed in the same cycle and held → yidong stays 00000. Release btn_right → yidong = 00001 for 8 cycles.
4. btn_down held; btn_up pressed during HOLD; btn_down released → only 00010 is emitted while down is held. After release, 00001 appears once the FSM returns to IDLE.
5. btn_place pressed; rst pulsed for 1 cycle at HOLD cycle 4 → yidong = 0 and busy = 0 on the next edge, flag stays 0. With the button still held after reset, a new 10000 command appears after the full debounce.
6. Glitch pulses of 1–3 cycles on btn_right, repeated 10 times → yidong never leaves 00000.

Source files
------------

// File: rtl/key_cmd_encoder.sv
// Push-button front-end for the gomoku board: sync + debounce five keys and emit
// one stretched one-hot command per press, with auto-repeat on direction keys.
module key_cmd_encoder #(
    parameter int DEBOUNCE_CYC = 2000000,
    parameter int HOLD_CYC     = 14000002,
    parameter int REPEAT_DLY   = 50000000,
    parameter int REPEAT_GAP   = 14000002
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_place,
    output logic [4:0] yidong,
    output logic       flag,
    output logic       busy
);
    localparam int NUM_KEYS = 5;
    localparam logic [NUM_KEYS-1:0] KEY_PLACE = 5'b10000;

    localparam int DW      = $clog2(DEBOUNCE_CYC + 1);
    localparam int HW      = $clog2(HOLD_CYC + 1);
    localparam int RPT_MAX = (REPEAT_DLY > REPEAT_GAP) ? REPEAT_DLY : REPEAT_GAP;
    localparam int RW      = $clog2(RPT_MAX + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'((DEBOUNCE_CYC > 0) ? DEBOUNCE_CYC - 1 : 0);
    localparam logic [HW-1:0] HOLD_LOAD = HW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    localparam logic [RW-1:0] DLY_LOAD  = RW'((REPEAT_DLY > 0) ? REPEAT_DLY - 1 : 0);
    localparam logic [RW-1:0] GAP_LOAD  = RW'((REPEAT_GAP > 0) ? REPEAT_GAP - 1 : 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [NUM_KEYS-1:0] btn_raw;
    logic [NUM_KEYS-1:0] key;

    assign btn_raw = {btn_place, btn_right, btn_left, btn_down, btn_up};

    // Per-key 2-flop synchroniser followed by a stability counter.
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        logic [1:0]    sync_pipe;
        logic [DW-1:0] deb_cnt;
        logic          level;

        always_ff @(posedge clk) begin
            if (rst) begin
                sync_pipe <= '0;
                deb_cnt   <= '0;
                level     <= 1'b0;
            end else begin
                sync_pipe <= {sync_pipe[0], btn_raw[i]};
                if (sync_pipe[1] == level) begin
                    deb_cnt <= '0;
                end else if (deb_cnt == DEB_LAST) begin
                    level   <= ~level;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end
        end

        assign key[i] = level;
    end

    logic [1:0]          state;
    logic [NUM_KEYS-1:0] cmd;
    logic [HW-1:0]       hold_cnt;
    logic [RW-1:0]       rpt_cnt;
    logic                rpt_mode;
    logic                key_onehot;
    logic                key_held;
    logic                is_dir;

    assign key_onehot = (key != '0) && ((key & (key - 1'b1)) == '0);
    assign key_held   = |(key & cmd);
    assign is_dir     = (cmd != KEY_PLACE);

    // yidong/busy are registered alongside the state so they never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cmd      <= '0;
            hold_cnt <= '0;
            rpt_cnt  <= '0;
            rpt_mode <= 1'b0;
            yidong   <= '0;
            busy     <= 1'b0;
            flag     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (key_onehot) begin
                        cmd      <= key;
                        hold_cnt <= HOLD_LOAD;
                        rpt_mode <= 1'b0;
                        yidong   <= key;
                        busy     <= 1'b1;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == '0) begin
                        yidong  <= '0;
                        busy    <= 1'b0;
                        rpt_cnt <= rpt_mode ? GAP_LOAD : DLY_LOAD;
                        if (!is_dir) flag <= ~flag;
                        state   <= ST_WAIT;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (!key_held) begin
                        state <= ST_IDLE;
                    end else if (is_dir && rpt_cnt == '0) begin
                        hold_cnt <= HOLD_LOAD;
                        rpt_mode <= 1'b1;
                        yidong   <= cmd;
                        busy     <= 1'b1;
                        state    <= ST_HOLD;
                    end else if (rpt_cnt != '0) begin
                        rpt_cnt <= rpt_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_cmd_encoder.sv
// Directed bench for key_cmd_encoder with a timestamp-based reference model.
module tb_key_cmd_encoder;
    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int DLY  = 20;
    localparam int GAP  = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
    logic       btn_right = 1'b0, btn_place = 1'b0;
    logic [4:0] yidong;
    logic       flag, busy;

    key_cmd_encoder #(
        .DEBOUNCE_CYC(DEB), .HOLD_CYC(HOLD), .REPEAT_DLY(DLY), .REPEAT_GAP(GAP)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_place(btn_place),
        .yidong(yidong), .flag(flag), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: keys become valid after DEB consecutive differing synced
    // samples; commands are scheduled by absolute cycle stamps.
    logic [4:0] m_s0 = '0, m_s1 = '0, m_lvl = '0, m_cmd = '0;
    int         m_run[5];
    int         m_mode = 0;   // 0 idle, 1 driving a command, 2 waiting
    int         m_cyc = 0, m_end = 0, m_rep = 0;
    bit         m_first = 1'b0;
    logic       m_flag = 1'b0;

    task automatic model_step();
        logic [4:0] raw;
        logic [4:0] synced;
        raw = {btn_place, btn_right, btn_left, btn_down, btn_up};
        m_cyc++;
        if (rst) begin
            m_s0 = '0; m_s1 = '0; m_lvl = '0; m_cmd = '0;
            m_mode = 0; m_flag = 1'b0;
            for (int i = 0; i < 5; i++) m_run[i] = 0;
            return;
        end
        case (m_mode)
            0: if ($countones(m_lvl) == 1) begin
                m_cmd = m_lvl; m_mode = 1; m_end = m_cyc + HOLD; m_first = 1'b1;
            end
            1: if (m_cyc == m_end) begin
                m_mode = 2;
                if (m_cmd == 5'b10000) m_flag = ~m_flag;
                m_rep = m_cyc + (m_first ? DLY : GAP);
            end
            default: if ((m_lvl & m_cmd) == 0) begin
                m_mode = 0;
            end else if (m_cmd != 5'b10000 && m_cyc >= m_rep) begin
                m_mode = 1; m_end = m_cyc + HOLD; m_first = 1'b0;
            end
        endcase
        synced = m_s1;
        m_s1 = m_s0;
        m_s0 = raw;
        for (int i = 0; i < 5; i++) begin
            if (synced[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_lvl[i] = ~m_lvl[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) m_run[i] = 0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("model yidong", int'(yidong), (m_mode == 1) ? int'(m_cmd) : 0);
            check("model busy", int'(busy), (m_mode == 1) ? 1 : 0);
            check("model flag", int'(flag), int'(m_flag));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Count negedges until yidong becomes non-zero, then check value and latency.
    task automatic wait_cmd(input string name, input int exp_cmd, input int exp_lat);
        int n;
        n = 0;
        while (n < 200 && yidong == 5'b0) begin
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, n, exp_lat);
        check({name, " cmd"}, int'(yidong), exp_cmd);
    endtask

    // Length of the current run of yidong == val, counting the present cycle.
    task automatic run_len(input string name, input logic [4:0] val, input int exp);
        int n;
        n = 0;
        while (n < 200 && yidong == val) begin
            n++;
            @(negedge clk);
        end
        check(name, n, exp);
    endtask

    task automatic quiet(input string name, input int n);
        logic [4:0] seen;
        seen = '0;
        repeat (n) begin
            @(negedge clk);
            seen |= yidong;
        end
        check(name, int'(seen), 0);
    endtask

    initial begin
        @(negedge clk);
        chk_en = 1'b1;
        check("reset yidong", int'(yidong), 0);
        check("reset busy", int'(busy), 0);
        check("reset flag", int'(flag), 0);
        cyc(2);
        rst = 1'b0;
        cyc(3);

        // 1: bounced left press, then held for auto-repeat
        btn_left = 1'b1; cyc(1); btn_left = 1'b0; cyc(1);
        btn_left = 1'b1; cyc(1); btn_left = 1'b0; cyc(1);
        btn_left = 1'b1;
        wait_cmd("t1 first", 5'b00100, 7);
        run_len("t1 hold1", 5'b00100, 8);
        run_len("t1 delay", 5'b00000, 20);
        run_len("t1 hold2", 5'b00100, 8);
        run_len("t1 gap", 5'b00000, 10);
        run_len("t1 hold3", 5'b00100, 8);
        check("t1 flag", int'(flag), 0);
        btn_left = 1'b0;
        cyc(20);

        // 2: place twice, no repeat, flag toggles each time
        btn_place = 1'b1;
        wait_cmd("t2 press1", 5'b10000, 7);
        run_len("t2 hold1", 5'b10000, 8);
        check("t2 flag after 1", int'(flag), 1);
        quiet("t2 no repeat", 25);
        btn_place = 1'b0;
        cyc(10);
        btn_place = 1'b1;
        wait_cmd("t2 press2", 5'b10000, 7);
        run_len("t2 hold2", 5'b10000, 8);
        check("t2 flag after 2", int'(flag), 0);
        btn_place = 1'b0;
        cyc(20);

        // 3: chord is ignored until it resolves to one key
        btn_up = 1'b1; btn_right = 1'b1;
        quiet("t3 chord", 20);
        btn_right = 1'b0;
        wait_cmd("t3 up", 5'b00001, 7);
        run_len("t3 hold", 5'b00001, 8);
        btn_up = 1'b0;
        cyc(20);

        // 4: second key during HOLD waits for the first to be released
        btn_down = 1'b1;
        wait_cmd("t4 down", 5'b00010, 7);
        cyc(2);
        btn_up = 1'b1;
        cyc(10);
        btn_down = 1'b0;
        wait_cmd("t4 up after", 5'b00001, 8);
        run_len("t4 hold", 5'b00001, 8);
        btn_up = 1'b0;
        cyc(20);

        // 5: reset in the middle of a place command
        btn_place = 1'b1;
        wait_cmd("t5 press", 5'b10000, 7);
        cyc(3);
        rst = 1'b1;
        cyc(1);
        check("t5 abort yidong", int'(yidong), 0);
        check("t5 abort busy", int'(busy), 0);
        check("t5 abort flag", int'(flag), 0);
        rst = 1'b0;
        wait_cmd("t5 repress", 5'b10000, 7);
        run_len("t5 hold", 5'b10000, 8);
        check("t5 flag", int'(flag), 1);
        btn_place = 1'b0;
        cyc(20);

        // 6: short glitches never debounce
        for (int k = 0; k < 10; k++) begin
            btn_right = 1'b1;
            cyc(1 + (k % 3));
            btn_right = 1'b0;
            cyc(5);
            check("t6 glitch", int'(yidong), 0);
        end
        quiet("t6 settle", 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
